data_memory: RTL and testbench

Memory responder on the far side of the register unit's RAM port: it consumes the address (AR), write data (DR) and read/write strobes produced by the processor and returns read data into DR. It holds a single-port word array of 2^ADDRESS_LEN × DATA_LEN. It runs a wait-state FSM so the control unit can be tested against a slow memory. A one-cycle `mem_ready` pulse marks completion, and `mem_busy` shows that an access is in flight.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/ram_array.sv | 33 +++
 rtl/data_memory.sv | 122 ++++++++++++
 tb/tb_data_memory.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data_memory wait-state responder: FSM states,
// the latched operation code and the width of the wait-state counter.
package mem_pkg;

  // Wait counter width; WAIT_STATES must fit in it (0..15).
  localparam int CNT_W = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Operation latched at request accept.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage : mem_pkg

// File: rtl/ram_array.sv
// Synchronous single-port word array. One access per enabled edge:
// either a write of wdata, or a read whose result is registered into rdata.
// rdata holds its value across writes and idle cycles.
module ram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Single-port access: write stores, read captures into the output register.
  // NOTE: the array and its read register have no reset so the tool can map
  // them onto a RAM macro; contents stay unknown until written.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule : ram_array

// File: rtl/data_memory.sv
// Slow memory responder for the processor's RAM port. A request is latched
// in IDLE, held for WAIT_STATES extra cycles in ACCESS, performed on the
// ACCESS->RESP edge and acknowledged with a one-cycle mem_ready in RESP.
// Requests that cannot be served (both strobes, or any strobe while busy)
// are dropped and flagged with a one-cycle mem_err.
module data_memory
  import mem_pkg::*;
#(
  parameter int ADDRESS_LEN = 8,
  parameter int DATA_LEN    = 16,
  parameter int WAIT_STATES = 2   // legal range 0..15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   read,
  input  logic                   write,
  input  logic [ADDRESS_LEN-1:0] ram_addr,
  input  logic [DATA_LEN-1:0]    ram_in,
  output logic [DATA_LEN-1:0]    ram_out,
  output logic                   mem_ready,
  output logic                   mem_busy,
  output logic                   mem_err
);

  state_t                 state;
  op_t                    op_q;
  logic [ADDRESS_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0]    data_q;
  logic [CNT_W-1:0]       cnt;
  logic                   rd_valid;
  logic [DATA_LEN-1:0]    rdata;

  logic one_req;
  logic any_req;
  logic both_req;
  logic access_done;

  assign one_req     = read ^ write;
  assign any_req     = read | write;
  assign both_req    = read & write;
  assign access_done = (state == ACCESS) && (cnt == '0);

  // The array sees only latched address/data, so input changes after the
  // accept edge cannot disturb the access in flight. The enable comes from
  // registered state, so an asynchronous reset drops a pending write.
  ram_array #(
    .ADDR_W (ADDRESS_LEN),
    .DATA_W (DATA_LEN)
  ) u_ram (
    .clk   (clk),
    .en    (access_done),
    .we    (access_done && (op_q == OP_WR)),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (rdata)
  );

  // The array's read register has no reset, so ram_out is forced to zero
  // until the first read after reset completes; afterwards it shows the
  // registered read data, which only changes when a read completes.
  assign ram_out = rd_valid ? rdata : '0;

  // Wait-state FSM with request latches, counter and registered flags.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, exactly like the hardware flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_RD;
      addr_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
      rd_valid  <= 1'b0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (one_req) begin
            state    <= ACCESS;
            op_q     <= write ? OP_WR : OP_RD;
            addr_q   <= ram_addr;
            data_q   <= ram_in;
            cnt      <= CNT_W'(WAIT_STATES);
            mem_busy <= 1'b1;
          end else if (both_req) begin
            mem_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (any_req) begin
            mem_err <= 1'b1;
          end
          if (cnt == '0) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            if (op_q == OP_RD) begin
              rd_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (any_req) begin
            mem_err <= 1'b1;
          end
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory. Three instances share clk/rst_n:
// index 0 with two wait states, index 1 with none, index 2 with four.
// Read results are predicted from a word model and queued when a read is
// driven, then popped and compared when mem_ready appears.
module tb_data_memory;

  localparam int N_DUT = 3;

  logic        clk;
  logic        rst_n;
  logic        rd    [N_DUT];
  logic        wr    [N_DUT];
  logic [7:0]  addr  [N_DUT];
  logic [15:0] din   [N_DUT];
  logic [15:0] out_v [N_DUT];
  logic        ready [N_DUT];
  logic        busy  [N_DUT];
  logic        err   [N_DUT];

  logic [15:0] model [N_DUT][256];
  logic [15:0] exp_q [$];

  int n_vec;
  int n_err;

  function automatic int ws(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
  endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 0 : 4);
    data_memory #(
      .ADDRESS_LEN (8),
      .DATA_LEN    (16),
      .WAIT_STATES (W)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .read      (rd[g]),
      .write     (wr[g]),
      .ram_addr  (addr[g]),
      .ram_in    (din[g]),
      .ram_out   (out_v[g]),
      .mem_ready (ready[g]),
      .mem_busy  (busy[g]),
      .mem_err   (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    check({tag, "_ram_out"}, 32'(out_v[k]), 32'h0);
    check({tag, "_ready"},   32'(ready[k]), 32'h0);
    check({tag, "_busy"},    32'(busy[k]),  32'h0);
    check({tag, "_err"},     32'(err[k]),   32'h0);
  endtask

  // One complete access on instance k, with latency and pulse checks.
  task automatic access(input int k, input bit is_wr, input logic [7:0] a,
                        input logic [15:0] d);
    int          lat;
    bit          stable;
    logic [15:0] prev;
    @(negedge clk);
    rd[k]   = !is_wr;
    wr[k]   = is_wr;
    addr[k] = a;
    din[k]  = d;
    if (is_wr) model[k][a] = d;
    else       exp_q.push_back(model[k][a]);
    prev = out_v[k];
    @(negedge clk);
    // Scramble the inputs: the access in flight must use the latched copy.
    rd[k]   = 1'b0;
    wr[k]   = 1'b0;
    addr[k] = ~a;
    din[k]  = ~d;
    check("accept_busy", 32'(busy[k]), 32'h1);
    lat    = 0;
    stable = 1'b1;
    while (!ready[k] && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!ready[k] && out_v[k] !== prev) stable = 1'b0;
    end
    check("ready_latency", 32'(lat), 32'(ws(k) + 1));
    check("out_stable_while_waiting", 32'(stable), 32'h1);
    if (ready[k]) begin
      if (!is_wr) check("read_data", 32'(out_v[k]), 32'(exp_q.pop_front()));
      else        check("write_keeps_out", 32'(out_v[k]), 32'(prev));
      check("busy_in_resp", 32'(busy[k]), 32'h1);
      @(negedge clk);
      check("ready_one_cycle", 32'(ready[k]), 32'h0);
      check("idle_after_resp", 32'(busy[k]),  32'h0);
      check("no_err_normal",   32'(err[k]),   32'h0);
    end else if (!is_wr) begin
      void'(exp_q.pop_front());
    end
  endtask

  // Back-to-back on the zero-wait instance with read held through busy.
  task automatic back_to_back();
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 8'h00; din[1] = 16'h1234;
    model[1][8'h00] = 16'h1234;
    @(negedge clk);                              // after accept edge N
    wr[1] = 1'b0; rd[1] = 1'b1; addr[1] = 8'h00; din[1] = 16'hFFFF;
    exp_q.push_back(model[1][8'h00]);
    check("b2b_busy_n",  32'(busy[1]), 32'h1);
    check("b2b_err_n",   32'(err[1]),  32'h0);
    @(negedge clk);                              // after N+1: RESP
    check("b2b_ready_n1", 32'(ready[1]), 32'h1);
    check("b2b_err_n1",   32'(err[1]),   32'h1);
    @(negedge clk);                              // after N+2: IDLE
    check("b2b_busy_n2",  32'(busy[1]), 32'h0);
    check("b2b_err_n2",   32'(err[1]),  32'h1);
    @(negedge clk);                              // after N+3: read accepted
    rd[1] = 1'b0;
    check("b2b_accept_n3", 32'(busy[1]), 32'h1);
    check("b2b_err_n3",    32'(err[1]),  32'h0);
    @(negedge clk);                              // after N+4: RESP
    check("b2b_ready_n4", 32'(ready[1]), 32'h1);
    check("b2b_read_data", 32'(out_v[1]), 32'(exp_q.pop_front()));
    @(negedge clk);
    check("b2b_idle_n5", 32'(busy[1]), 32'h0);
  endtask

  // Both strobes in IDLE: rejected with a single mem_err cycle.
  task automatic both_strobes();
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h05; din[0] = 16'hAAAA;
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b0;
    check("both_err",  32'(err[0]),  32'h1);
    check("both_busy", 32'(busy[0]), 32'h0);
    @(negedge clk);
    check("both_err_cleared", 32'(err[0]),  32'h0);
    check("both_still_idle",  32'(busy[0]), 32'h0);
  endtask

  // Reset asserted while a write on the four-wait instance is in ACCESS.
  task automatic reset_mid_write();
    @(negedge clk);
    wr[2] = 1'b1; addr[2] = 8'h20; din[2] = 16'h5555;   // model not updated
    @(negedge clk);
    wr[2] = 1'b0;
    check("rmw_busy", 32'(busy[2]), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(2, "rmw");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs(2, "rmw_released");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int k = 0; k < N_DUT; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; din[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N_DUT; k++) check_reset_outputs(k, "reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < N_DUT; k++) check_reset_outputs(k, "quiet");

    // Write then read, two wait states.
    access(0, 1'b1, 8'h12, 16'hBEEF);
    access(0, 1'b0, 8'h12, 16'h0000);

    // Zero wait states, back-to-back with read held.
    back_to_back();

    // Rejected dual strobe leaves prior contents.
    access(0, 1'b1, 8'h05, 16'h1111);
    both_strobes();
    access(0, 1'b0, 8'h05, 16'h0000);

    // Reset mid-write keeps the preloaded word.
    access(2, 1'b1, 8'h20, 16'h0F0F);
    reset_mid_write();
    access(2, 1'b0, 8'h20, 16'h0000);

    // Full address sweep on the two-wait instance.
    for (int a = 0; a < 256; a++) access(0, 1'b1, 8'(a), 16'(a) ^ 16'h00FF);
    for (int a = 0; a < 256; a++) access(0, 1'b0, 8'(a), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_memory
